// File: rtl/loop_ctrl_pkg.sv
// Shared types and limits for the nested-loop sequencer.
package loop_ctrl_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DEF_W = 20;
  localparam int MAX_D = 4;

endpackage

// File: rtl/loop_cnt.sv
// One odometer digit: W-bit counter that returns to zero after reaching its bound.
// Registered val and at_max; at_max_nxt is the compare for the value being loaded this edge.
module loop_cnt
  import loop_ctrl_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] bound,
  output logic [W-1:0] val,
  output logic         at_max,
  output logic         at_max_nxt
);

  logic [W-1:0] val_nxt;

  // The bound compare happens before the increment, so an all-ones bound never carries out.
  always_comb begin
    val_nxt = val;
    if (clr) begin
      val_nxt = '0;
    end else if (en) begin
      val_nxt = at_max ? '0 : val + W'(1);
    end
  end

  assign at_max_nxt = (val_nxt == bound);

  always_ff @(posedge clk) begin
    if (rst) begin
      val    <= '0;
      at_max <= 1'b0;
    end else begin
      val    <= val_nxt;
      at_max <= at_max_nxt;
    end
  end

endmodule

// File: rtl/loop_ctrl.sv
// Nested-loop sequencer: issues every index tuple up to the latched bounds, innermost first.
// First beat one cycle after start; one beat per cycle; idx/wrap hold while ready is low.
module loop_ctrl
  import loop_ctrl_pkg::*;
#(
  parameter int W = DEF_W,
  parameter int D = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [D-1:0][W-1:0] bound,
  input  logic                abort,
  input  logic                ready,
  output logic                exec,
  output logic [D-1:0][W-1:0] idx,
  output logic [D-1:0]        wrap,
  output logic                busy,
  output logic                fin
);

  state_t              state_q, state_d;
  logic [D-1:0][W-1:0] bound_q, bound_sel;
  logic [D-1:0]        at_max, at_max_nxt, wrap_nxt;
  logic [D:0]          carry, pfx;
  logic                launch, consume, done;

  assign launch    = (state_q == IDLE) && start && !abort;
  assign consume   = exec && ready;
  assign bound_sel = launch ? bound : bound_q;

  // carry[d] enables digit d; carry[D] means the final tuple was just consumed.
  assign carry[0] = consume && !abort;
  assign pfx[0]   = 1'b1;
  assign done     = carry[D];

  generate
    for (genvar d = 0; d < D; d++) begin : g_dim
      assign carry[d+1]  = carry[d] & at_max[d];
      assign pfx[d+1]    = pfx[d] & at_max_nxt[d];
      assign wrap_nxt[d] = pfx[d+1];

      loop_cnt #(.W(W)) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .clr        (launch),
        .en         (carry[d]),
        .bound      (bound_sel[d]),
        .val        (idx[d]),
        .at_max     (at_max[d]),
        .at_max_nxt (at_max_nxt[d])
      );
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (launch) state_d = RUN;
      RUN:     if (abort || done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign busy = (state_q == RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      bound_q <= '0;
      exec    <= 1'b0;
      wrap    <= '0;
      fin     <= 1'b0;
    end else begin
      fin <= done;
      if (launch) begin
        bound_q <= bound;
        exec    <= 1'b1;
        wrap    <= wrap_nxt;
      end else if (abort || done) begin
        exec <= 1'b0;
        wrap <= '0;
      end else if (carry[0]) begin
        wrap <= wrap_nxt;
      end
    end
  end

endmodule

// File: doc/loop_ctrl.md
# loop_ctrl

Parametrised nested-loop sequencer: the next generation of the two-level get controller. It walks a D-dimensional index space from zero up to per-dimension inclusive bounds, innermost dimension first. Each index tuple is issued as a valid/ready beat. The block flags every dimension rollover, pulses a finish strobe, and supports abort. It sits between the host command decode and the compute datapath, and drives its exec/index/wrap outputs straight into the PE array.

## Interface
- W, 20: index/bound width per dimension
- D, 2: number of loop dimensions (1..4); dimension 0 is innermost

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  launch request; accepted only when busy=0
- bound  in  D×W  inclusive final index per dimension; sampled on the accepting edge of start
- abort  in  1  cancel the current run
- ready  in  1  downstream accepts the current beat
- exec  out  1  beat valid
- idx  out  D×W  index tuple of the current beat
- wrap  out  D  wrap[d]=1 when idx[0..d] all equal their bounds (dimension d completes on this beat)
- busy  out  1  run in progress (state RUN)
- fin  out  1  one-cycle pulse after the last beat is consumed

## Operation
- States: IDLE, RUN. Reset → IDLE. All outputs are registered; reset value of exec, idx, wrap, busy and fin is 0.
- **IDLE → RUN** on `start & ~abort`:
  - latch bound;
  - set idx←0, exec←1;
  - set wrap from zero-vs-bound compare.
- **Beat consumed** when `exec & ready`:
  - If `wrap[D-1]=1` (last beat): exec←0, fin←1, go to IDLE.
  - Otherwise advance odometer: idx[0]+1. If idx[0] was at its bound, it resets to 0 and dimension 1 increments, and so on up the dimensions. Recompute wrap for the new tuple in the same edge.
- **Handshake**:
  - `exec & ~ready`: idx, wrap and exec hold unchanged.
  - exec never drops without consumption, except on abort or rst.
- **Compare before increment**: bound=2^W−1 never overflows the counter. Every arithmetic result is exactly W bits, with no carry out.
- **start while busy**: ignored; latched bounds do not change.
- **abort in RUN**: next edge gives exec←0, wrap←0, IDLE, and no fin. A beat consumed on the same edge as abort is still counted as consumed, but no further beats are issued. If abort and start are both high in IDLE, start is ignored.
- **rst mid-run**: returns to IDLE, all outputs 0, no fin.
- **All bounds 0**: a single beat with wrap all ones, then fin.

## Timing
- start sampled high at edge t → exec=1, idx=0 visible after edge t (latency 1).
- With ready held high, beats come back-to-back, one per cycle. Total beats = Π(bound[d]+1).
- Last beat consumed at edge k → fin=1 for the cycle after k only. busy falls at the same edge.
- A new start is accepted on the edge while fin is high (busy=0). The next run's first beat follows one cycle after that.
- Throughput is 1 beat per cycle. There is no bubble at dimension rollovers.

## Structure
- **Package loop_ctrl_pkg**: state enum {IDLE, RUN}, the default W, and the D upper limit of 4.
- **Sub-module loop_cnt** (one per dimension, generate loop). It is a W-bit counter with:
  - ports clr, en, bound;
  - outputs val and at_max (val==bound).
  - Dimension d is enabled by `consume & at_max[0..d-1]`.
- The top level holds the FSM, the bound latch, the wrap/prefix-AND logic and the output registers.

## Test plan
- **D=2, bound={0:2, 1:1}, ready=1**: 6 beats (0,0)(1,0)(2,0)(0,1)(1,1)(2,1). wrap[0] is set on beats 3 and 6, wrap[1] only on beat 6. fin fires 1 cycle after beat 6, which is 7 cycles after the start edge.
- **All bounds 0**: exactly 1 beat with wrap=2'b11, then fin, then busy=0.
- **Backpressure**: bound={3,0}, ready toggling 1,0,0,1… → idx/wrap hold during ready=0. The sequence 0..3 appears with no skips or duplicates, and fin comes only after beat 3 is consumed.
- **Abort on the 2nd beat with ready=0**: exec drops the next cycle, no fin. A start issued 1 cycle later begins again from (0,0).
- **start pulsed mid-run with different bounds**: ignored; the original count is completed. Then rst asserted mid-run → all outputs 0 on the next cycle, no fin.
- **D=3, W=4, all bounds 15**: 4096 beats with no counter overflow. wrap[2] is set only on the final beat (15,15,15).
